// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle controller: opcodes, FSM states and datapath mux/ALU codes.
// Purely declarative; no logic, so no latency or backpressure of its own.
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [1:0] ASB_B       = 2'b00;
    localparam logic [1:0] ASB_FOUR    = 2'b01;
    localparam logic [1:0] ASB_IMM     = 2'b10;
    localparam logic [1:0] ASB_IMM_SH2 = 2'b11;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_FETCH     = 4'd1,
        ST_DECODE    = 4'd2,
        ST_MEM_ADDR  = 4'd3,
        ST_MEM_READ  = 4'd4,
        ST_MEM_WB    = 4'd5,
        ST_MEM_WRITE = 4'd6,
        ST_EXECUTE   = 4'd7,
        ST_ALU_WB    = 4'd8,
        ST_BRANCH    = 4'd9,
        ST_JUMP      = 4'd10,
        ST_ADDI_EXEC = 4'd11,
        ST_ADDI_WB   = 4'd12
    } state_t;

endpackage

// File: rtl/mc_control.sv
// Multicycle CPU control FSM: Moore outputs decoded from the state register, one state per cycle.
// Memory states stall on mem_ready=0; FETCH gates its PC/IR writes with mem_ready.
module mc_control
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state
);

    state_t state_q, state_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    assign state = state_q;

    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = ASB_B;
        alu_op        = ALUOP_ADD;
        pc_source     = PCSRC_ALU;

        case (state_q)
            ST_IDLE: state_d = ST_FETCH;
            ST_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = ASB_FOUR;
                alu_op    = ALUOP_ADD;
                // PC+4 and IR load only commit on the cycle the fetch completes
                pc_write  = mem_ready;
                ir_write  = mem_ready;
                if (mem_ready) state_d = ST_DECODE;
            end
            ST_DECODE: begin
                alu_src_b = ASB_IMM_SH2;
                alu_op    = ALUOP_ADD;
                case (op)
                    OP_LW, OP_SW: state_d = ST_MEM_ADDR;
                    OP_RTYPE:     state_d = ST_EXECUTE;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_J:         state_d = ST_JUMP;
                    OP_ADDI:      state_d = ST_ADDI_EXEC;
                    default:      state_d = ST_FETCH;
                endcase
            end
            ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = ASB_IMM;
                state_d   = (op == OP_LW) ? ST_MEM_READ : ST_MEM_WRITE;
            end
            ST_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) state_d = ST_MEM_WB;
            end
            ST_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) state_d = ST_FETCH;
            end
            ST_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_src_b = ASB_B;
                alu_op    = ALUOP_FUNCT;
                state_d   = ST_ALU_WB;
            end
            ST_ALU_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_src_b     = ASB_B;
                alu_op        = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                state_d       = ST_FETCH;
            end
            ST_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
                state_d   = ST_FETCH;
            end
            ST_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = ASB_IMM;
                state_d   = ST_ADDI_WB;
            end
            ST_ADDI_WB: begin
                reg_write = 1'b1;
                state_d   = ST_FETCH;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mc_control.sv
// Directed-vector bench for mc_control; expected state/output values are written out by hand.
module tb_mc_control;
    import mc_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] op = 6'b000000;
    logic       mem_ready = 1'b1;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       reg_write, reg_dst, mem_to_reg, alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    int total = 0;
    int bad   = 0;

    mc_control dut (
        .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .state(state)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Field order: pcw pwc iod mr mw irw rw rd m2r asa asb aop psrc
    function automatic logic [15:0] pk(input logic pcw, input logic pwc, input logic iod,
                                       input logic mr, input logic mw, input logic irw,
                                       input logic rw, input logic rd, input logic m2r,
                                       input logic asa, input logic [1:0] asb,
                                       input logic [1:0] aop, input logic [1:0] psrc);
        return {pcw, pwc, iod, mr, mw, irw, rw, rd, m2r, asa, asb, aop, psrc};
    endfunction

    function automatic logic [15:0] outs();
        return {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_st(input string tag, input logic [3:0] exp);
        check(tag, {12'd0, state}, {12'd0, exp});
    endtask

    initial begin
        int cyc;
        #3;
        chk_st("rst_state", 4'd0);
        check("rst_outs", outs(), 16'h0000);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_st("rel_idle", 4'd0);
        step();
        chk_st("rel_fetch", 4'd1);

        // lw with mem_ready=1 : 5 cycles
        op = 6'b100011;
        check("lw_fetch_o", outs(), pk(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00));
        step(); chk_st("lw_decode", 4'd2);
        check("lw_decode_o", outs(), pk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00));
        step(); chk_st("lw_memaddr", 4'd3);
        check("lw_memaddr_o", outs(), pk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00));
        step(); chk_st("lw_memread", 4'd4);
        check("lw_memread_o", outs(), pk(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00));
        step(); chk_st("lw_memwb", 4'd5);
        check("lw_memwb_o", outs(), pk(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00));
        step(); chk_st("lw_end_fetch", 4'd1);

        // FETCH wait states, then sw with one MEM_WRITE stall
        mem_ready = 1'b0;
        op = 6'b101011;
        #1;
        check("wait_o0", outs(), pk(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00));
        for (int i = 0; i < 3; i++) begin
            step();
            chk_st($sformatf("wait_st%0d", i), 4'd1);
            check($sformatf("wait_pcw_irw%0d", i), {14'd0, pc_write, ir_write}, 16'd0);
        end
        mem_ready = 1'b1;
        #1;
        check("wait_ready_pcw", {15'd0, pc_write}, 16'd1);
        step(); chk_st("sw_decode", 4'd2);
        step(); chk_st("sw_memaddr", 4'd3);
        mem_ready = 1'b0;
        step(); chk_st("sw_memwrite", 4'd6);
        check("sw_memwrite_o", outs(), pk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00));
        step(); chk_st("sw_memwrite_hold", 4'd6);
        mem_ready = 1'b1;
        step(); chk_st("sw_end_fetch", 4'd1);

        // beq : 3 cycles
        op = 6'b000100;
        step(); chk_st("beq_decode", 4'd2);
        step(); chk_st("beq_branch", 4'd9);
        check("beq_branch_o", outs(), pk(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01));
        step(); chk_st("beq_end_fetch", 4'd1);

        // illegal opcode returns straight to FETCH with no writes
        op = 6'b111111;
        step(); chk_st("ill_decode", 4'd2);
        check("ill_rw_mw", {14'd0, reg_write, mem_write}, 16'd0);
        step(); chk_st("ill_fetch", 4'd1);
        check("ill_fetch_rw_mw", {14'd0, reg_write, mem_write}, 16'd0);

        // j : count edges from FETCH back to FETCH
        op = 6'b000010;
        cyc = 0;
        step(); cyc++;
        step(); cyc++;
        chk_st("j_jump", 4'd10);
        check("j_jump_o", outs(), pk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10));
        while (state != 4'd1 && cyc < 10) begin
            step(); cyc++;
        end
        check("j_cycles", 16'(cyc), 16'd3);

        // R-type
        op = 6'b000000;
        step(); step(); chk_st("r_execute", 4'd7);
        check("r_execute_o", outs(), pk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00));
        step(); chk_st("r_aluwb", 4'd8);
        check("r_aluwb_o", outs(), pk(0,0,0,0,0,0,1,1,0,0,2'b00,2'b00,2'b00));
        step(); chk_st("r_end_fetch", 4'd1);

        // addi
        op = 6'b001000;
        step(); step(); chk_st("addi_exec", 4'd11);
        check("addi_exec_o", outs(), pk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00));
        step(); chk_st("addi_wb", 4'd12);
        check("addi_wb_o", outs(), pk(0,0,0,0,0,0,1,0,0,0,2'b00,2'b00,2'b00));
        step(); chk_st("addi_end_fetch", 4'd1);

        // reset asserted while MEM_READ is stalled
        op = 6'b100011;
        step(); step(); step();
        chk_st("rstmid_memread", 4'd4);
        mem_ready = 1'b0;
        step(); chk_st("rstmid_hold", 4'd4);
        #2;
        rst = 1'b1;
        #1;
        chk_st("rstmid_state", 4'd0);
        check("rstmid_outs", outs(), 16'h0000);
        step();
        chk_st("rstmid_held_idle", 4'd0);
        #2;
        rst = 1'b0;
        mem_ready = 1'b1;
        #1;
        chk_st("rstmid_rel_idle", 4'd0);
        step();
        chk_st("rstmid_rel_fetch", 4'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 SHALL have port clk, input, 1 bit: single system clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-003 SHALL have port op, input, 6 bits: instruction opcode from the instruction register.
REQ-004 SHALL have port mem_ready, input, 1 bit: memory access completes this cycle.
REQ-005 SHALL have port pc_write, output, 1 bit: unconditional PC load.
REQ-006 SHALL have port pc_write_cond, output, 1 bit: PC load if ALU zero.
REQ-007 SHALL have port i_or_d, output, 1 bit: memory address source; 0 = PC, 1 = ALUOut.
REQ-008 SHALL have ports mem_read and mem_write, outputs, 1 bit each: memory strobes.
REQ-009 SHALL have ports ir_write, reg_write, reg_dst and mem_to_reg, outputs, 1 bit each.
REQ-010 SHALL have port alu_src_a, output, 1 bit: 0 = PC, 1 = register A.
REQ-011 SHALL have port alu_src_b, output, 2 bits: selects the 4:1 ALU-B mux; 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
REQ-012 SHALL have port alu_op, output, 2 bits: 00 = add, 01 = subtract, 10 = use funct field.
REQ-013 SHALL have port pc_source, output, 2 bits: 00 = ALU result, 01 = ALUOut, 10 = jump target.
REQ-014 SHALL have port state, output, 4 bits: current state encoding, for debug.

Function
REQ-015 SHALL implement these Moore states: IDLE, FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB, MEM_WRITE, EXECUTE, ALU_WB, BRANCH, JUMP, ADDI_EXEC, ADDI_WB.
REQ-016 SHALL drive every output not listed for the current state to 0.
REQ-017 IDLE SHALL assert nothing and SHALL move to FETCH on the next edge.
REQ-018 FETCH SHALL assert mem_read=1, alu_src_b=01 and alu_op=00.
REQ-019 FETCH SHALL assert pc_write and ir_write only when mem_ready=1.
REQ-020 FETCH SHALL hold while mem_ready=0 and SHALL go to DECODE when mem_ready=1.
REQ-021 DECODE SHALL assert alu_src_b=11 and alu_op=00.
REQ-022 DECODE SHALL branch on op: 100011 or 101011 -> MEM_ADDR; 000000 -> EXECUTE; 000100 -> BRANCH; 000010 -> JUMP; 001000 -> ADDI_EXEC.
REQ-023 DECODE SHALL go to FETCH for any other opcode, with no register or memory write.
REQ-024 MEM_ADDR and ADDI_EXEC SHALL assert alu_src_a=1 and alu_src_b=10.
REQ-025 MEM_ADDR SHALL go to MEM_READ when op=100011 and to MEM_WRITE otherwise; ADDI_EXEC SHALL go to ADDI_WB.
REQ-026 MEM_READ SHALL assert mem_read and i_or_d, SHALL hold while mem_ready=0, and SHALL go to MEM_WB when mem_ready=1.
REQ-027 MEM_WRITE SHALL assert mem_write and i_or_d, SHALL hold while mem_ready=0, and SHALL go to FETCH when mem_ready=1.
REQ-028 MEM_WB SHALL assert reg_write=1, mem_to_reg=1 and reg_dst=0, then go to FETCH.
REQ-029 EXECUTE SHALL assert alu_src_a=1, alu_src_b=00 and alu_op=10, then go to ALU_WB.
REQ-030 ALU_WB SHALL assert reg_write=1 and reg_dst=1, then go to FETCH.
REQ-031 ADDI_WB SHALL assert reg_write=1 and reg_dst=0, then go to FETCH.
REQ-032 BRANCH SHALL assert alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1 and pc_source=01, then go to FETCH.
REQ-033 JUMP SHALL assert pc_write=1 and pc_source=10, then go to FETCH.
REQ-034 SHALL sample op only in DECODE and MEM_ADDR.
REQ-035 SHALL give these per-instruction cycle counts with mem_ready always 1: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.

Reset
REQ-036 SHALL force the state to IDLE and all outputs to 0 immediately on rst=1, including mid-instruction and while waiting on mem_ready.
REQ-037 SHALL enter FETCH on the first rising clk edge after rst deasserts.

Structure
REQ-038 SHALL place opcode constants, state encodings and the alu_src_b/pc_source/alu_op codes in a shared package, mc_pkg.
REQ-039 SHALL be a single module with no sub-modules, consisting of a state register, next-state logic and output decode.

Verification
REQ-040 The bench SHALL check reset: rst=1 mid-MEM_READ -> state=IDLE and all outputs 0 at once; after release, IDLE then FETCH.
REQ-041 The bench SHALL check lw (op=100011) with mem_ready=1: states FETCH, DECODE, MEM_ADDR, MEM_READ, MEM_WB; reg_write=1 with mem_to_reg=1 in cycle 5.
REQ-042 The bench SHALL check wait states: FETCH with mem_ready=0 for 3 cycles -> state held, pc_write=0 and ir_write=0 throughout; pc_write=1 on the mem_ready=1 cycle.
REQ-043 The bench SHALL check beq (op=000100): BRANCH has alu_op=01, pc_write_cond=1 and pc_source=01; the next state is FETCH.
REQ-044 The bench SHALL check an illegal opcode (op=111111): DECODE -> FETCH, with reg_write and mem_write never asserted.
REQ-045 The bench SHALL check j (op=000010): JUMP has pc_write=1 and pc_source=10, for a 3-cycle instruction.
